instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. It holds the program counter, requests instructions from instruction memory over a req/ack handshake that tolerates wait states, and presents a stable instruction word to the decode/control stage. It consumes the control stage's PCSRC decision together with the branch/jump target to select the next PC.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction word driven while no valid instruction is held (addi x0,x0,0).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- PCSRC  in  1  taken branch/jump from the control stage; sampled only on retire.
- PC_TARGET  in  32  branch/jump target address; sampled only on retire.
- STALL  in  1  downstream hold; freezes the presented instruction.
- IMEM_REQ  out  1  instruction memory read request.
- IMEM_ADDR  out  32  read address, equals PC.
- IMEM_ACK  in  1  memory returns IMEM_RDATA this cycle.
- IMEM_RDATA  in  32  instruction word from memory.
- INSTRUCTION  out  32  registered instruction presented to decode/control.
- INSTR_VALID  out  1  INSTRUCTION/PC valid for execution this cycle.
- PC  out  32  address of INSTRUCTION.
- PC_PLUS4  out  32  PC + 4, combinational from PC, for JAL link.
- RETIRE_COUNT  out  32  count of retired instructions.
- MISALIGN  out  1  sticky misaligned-target trap flag.

## Operation

- FSM states: REQ, VALID, TRAP. TRAP exists only with the macro.
- Reset, synchronous: state=REQ, PC=RESET_PC, INSTRUCTION=NOP_INSTR, INSTR_VALID=0, RETIRE_COUNT=0, MISALIGN=0. IMEM_REQ=1 in the first cycle after reset.
- REQ:
  - IMEM_REQ=1; IMEM_ADDR=PC, held stable until ack.
  - On IMEM_ACK: INSTRUCTION<=IMEM_RDATA, next state=VALID.
  - Without ack: remain in REQ and keep the request asserted.
- VALID:
  - IMEM_REQ=0, INSTR_VALID=1.
  - STALL=1: hold all state.
  - STALL=0 (retire):
    - PC <= PCSRC ? PC_TARGET : PC+4.
    - RETIRE_COUNT += 1.
    - Next state=REQ.
- IMEM_ACK outside REQ: ignored. IMEM_RDATA is not captured.
- PC+4 arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- RETIRE_COUNT wraps from 32'hFFFF_FFFF to 0.
- INSTRUCTION keeps its last captured word in REQ. INSTR_VALID=0 qualifies it.
- RST asserted while in REQ or VALID: an outstanding request is abandoned. Any IMEM_ACK in the reset cycle is ignored. The fetch restarts at RESET_PC.

## Timing

- IMEM_ACK is allowed in the same cycle IMEM_REQ rises (zero wait).
- Zero-wait throughput: 1 instruction per 2 cycles (REQ, VALID).
- Each memory wait cycle adds 1 cycle.
- Latency:
  - From the ack edge to INSTR_VALID=1: 1 cycle.
  - From retire to the new IMEM_ADDR: 1 cycle. The new PC is visible in the REQ cycle.
- PCSRC and PC_TARGET are don't-care except in VALID with STALL=0.
- STALL is don't-care outside VALID.
- Outputs are registered except IMEM_ADDR (=PC register), PC_PLUS4 and IMEM_REQ/INSTR_VALID (decoded from the state register).

## Configuration

- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - On retire with PCSRC=1 and PC_TARGET[1:0]!=2'b00: next state=TRAP, MISALIGN<=1.
  - PC stays at the faulting instruction's address. RETIRE_COUNT is not incremented.
  - In TRAP: IMEM_REQ=0, INSTR_VALID=0, all ignored until RST.
- Undefined:
  - PC_TARGET[1:0] is forced to 2'b00 when loaded.
  - TRAP is unreachable. MISALIGN is tied to 0. The port exists in both builds.

## Test plan

- Reset with RESET_PC=32'h100 and IMEM_ACK tied high → IMEM_ADDR sequence 0x100, 0x104, 0x108 with INSTR_VALID in alternating cycles; RETIRE_COUNT=3 after three VALID cycles.
- Memory with 3 wait states → IMEM_REQ and IMEM_ADDR held constant for 4 cycles. INSTRUCTION is captured only on the ack cycle. INSTR_VALID rises exactly 1 cycle later.
- VALID at PC=0x20 with PCSRC=1, PC_TARGET=0x08 → next IMEM_ADDR=0x08. The same with PCSRC=0 → 0x24. PC_PLUS4=0x24 while PC=0x20.
- STALL high for 5 VALID cycles with PCSRC toggling → PC, INSTRUCTION and RETIRE_COUNT unchanged; the PC update uses only the values in the first cycle with STALL=0.
- PC=32'hFFFF_FFFC, no branch → next PC=0. RST asserted mid-REQ with a coincident ack → INSTRUCTION=NOP_INSTR and PC=RESET_PC the next cycle.
- PCSRC=1 with PC_TARGET=0x0000_0042:
  - With the macro: MISALIGN=1, IMEM_REQ stays 0, PC stays at the faulting address.
  - Without the macro: next IMEM_ADDR=0x40, MISALIGN=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage for the single-cycle RISC-V core.
// Holds the PC, fetches one instruction per REQ/VALID round trip over a
// req/ack memory handshake (wait states allowed) and presents the word to
// decode until the control stage retires it.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a taken branch/jump to a
// non word-aligned target traps (sticky MISALIGN, fetch halts until reset).
// Without it the target's low two bits are cleared and MISALIGN reads 0.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCSRC,
    input  logic [31:0] PC_TARGET,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] RETIRE_COUNT,
    output logic        MISALIGN
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_VALID = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_VALID = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] pc_plus4;

    // PC + 4 wraps modulo 2^32 and doubles as the JAL link value
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
`endif

    // Next-state logic: capture on ack in REQ, advance the PC on retire in VALID
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (IMEM_ACK) begin
                    instr_d = IMEM_RDATA;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!STALL) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (PCSRC && (PC_TARGET[1:0] != 2'b00)) begin
                        // Faulting instruction does not retire; PC stays on it
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d     = PCSRC ? PC_TARGET : pc_plus4;
                        retire_d = retire_q + 32'd1;
                        state_d  = ST_REQ;
                    end
`else
                    pc_d     = PCSRC ? (PC_TARGET & ~32'h3) : pc_plus4;
                    retire_d = retire_q + 32'd1;
                    state_d  = ST_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State registers; reset abandons any outstanding request and ignores ack
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            retire_q <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign IMEM_REQ     = (state_q == ST_REQ);
    assign INSTR_VALID  = (state_q == ST_VALID);
    assign IMEM_ADDR    = pc_q;
    assign PC           = pc_q;
    assign PC_PLUS4     = pc_plus4;
    assign INSTRUCTION  = instr_q;
    assign RETIRE_COUNT = retire_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign MISALIGN     = misalign_q;
`else
    assign MISALIGN     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a cycle-accurate driver plays memory and
// control stage, pushing expected fetch addresses and retired instructions
// into queues; an independent monitor checks the DUT against them.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PCSRC = 1'b0;
    logic [31:0] PC_TARGET = 32'd0;
    logic        STALL = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = 32'd0;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] RETIRE_COUNT;
    logic        MISALIGN;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCSRC       (PCSRC),
        .PC_TARGET   (PC_TARGET),
        .STALL       (STALL),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_VALID (INSTR_VALID),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .RETIRE_COUNT(RETIRE_COUNT),
        .MISALIGN    (MISALIGN)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } ret_t;

    logic [31:0] addr_q[$];
    ret_t        ret_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural PC and retired-instruction count
    logic [31:0] m_pc  = RST_PC;
    logic [31:0] m_cnt = 32'd0;
    bit          m_trap = 1'b0;
    logic [31:0] exp_hold = NOP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: consumes expected items whenever the DUT accepts a fetch or presents an instruction
    ret_t        mon_r;
    logic [31:0] mon_a;
    always @(negedge CLK) begin
        if (RST) begin
            exp_hold = NOP;
        end else begin
            if (IMEM_REQ) begin
                check("instr_held_in_req", INSTRUCTION, exp_hold);
                if (IMEM_ACK) begin
                    check("fetch_expected", addr_q.size(), (addr_q.size() == 0) ? 32'd1 : addr_q.size());
                    if (addr_q.size() != 0) begin
                        mon_a = addr_q.pop_front();
                        check("imem_addr", IMEM_ADDR, mon_a);
                        check("pc_plus4", PC_PLUS4, mon_a + 32'd4);
                    end
                end
            end
            if (INSTR_VALID) begin
                check("valid_expected", ret_q.size(), (ret_q.size() == 0) ? 32'd1 : ret_q.size());
                if (ret_q.size() != 0) begin
                    mon_r = ret_q[0];
                    check("pc", PC, mon_r.pc);
                    check("instruction", INSTRUCTION, mon_r.instr);
                    check("retire_count", RETIRE_COUNT, mon_r.cnt);
                    if (!STALL) begin
                        void'(ret_q.pop_front());
                        exp_hold = mon_r.instr;
                    end
                end
            end
        end
    end

    // One full fetch/retire round trip, starting at the beginning of a REQ cycle
    task automatic do_fetch(input int waits, input int stalls, input bit pcsrc, input logic [31:0] tgt);
        logic [31:0] rd;
        addr_q.push_back(m_pc);
        for (int i = 0; i < waits; i++) begin
            IMEM_ACK   = 1'b0;
            IMEM_RDATA = $urandom;
            STALL      = 1'($urandom);
            PCSRC      = 1'($urandom);
            step();
        end
        rd         = $urandom;
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = rd;
        step();
        ret_q.push_back('{pc: m_pc, instr: rd, cnt: m_cnt});
        for (int i = 0; i < stalls; i++) begin
            STALL      = 1'b1;
            PCSRC      = 1'($urandom);
            PC_TARGET  = $urandom;
            IMEM_ACK   = 1'($urandom);
            IMEM_RDATA = $urandom;
            step();
        end
        STALL      = 1'b0;
        PCSRC      = pcsrc;
        PC_TARGET  = tgt;
        IMEM_ACK   = 1'($urandom);
        IMEM_RDATA = $urandom;
        step();
        IMEM_ACK  = 1'b0;
        PCSRC     = 1'($urandom);
        PC_TARGET = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pcsrc && (tgt % 4 != 0)) begin
            m_trap = 1'b1;
            return;
        end
`endif
        m_pc  = pcsrc ? (tgt / 4) * 4 : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic do_reset(input bit with_ack, input int cycles);
        RST        = 1'b1;
        IMEM_ACK   = with_ack;
        IMEM_RDATA = $urandom;
        for (int i = 0; i < cycles; i++) step();
        RST      = 1'b0;
        IMEM_ACK = 1'b0;
        m_pc     = RST_PC;
        m_cnt    = 32'd0;
        m_trap   = 1'b0;
        @(negedge CLK);
        check("rst_imem_req", 32'(IMEM_REQ), 32'd1);
        check("rst_instr_valid", 32'(INSTR_VALID), 32'd0);
        check("rst_pc", PC, RST_PC);
        check("rst_imem_addr", IMEM_ADDR, RST_PC);
        check("rst_instruction", INSTRUCTION, NOP);
        check("rst_retire_count", RETIRE_COUNT, 32'd0);
        check("rst_misalign", 32'(MISALIGN), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        logic [31:0] fault_pc;
        do_reset(1'b0, 3);

        // Ack tied high: 0x100, 0x104, 0x108, then count shows 3 retired
        for (int i = 0; i < 3; i++) do_fetch(0, 0, 1'b0, 32'd0);
        // Three wait states, then a long stall with junk control inputs
        do_fetch(3, 0, 1'b0, 32'd0);
        do_fetch(0, 5, 1'b1, 32'h0000_0020);
        // At 0x20: taken branch to 0x08, later not-taken from 0x20 to 0x24
        do_fetch(1, 0, 1'b1, 32'h0000_0008);
        do_fetch(0, 0, 1'b1, 32'h0000_0020);
        do_fetch(0, 2, 1'b0, 32'h0000_0008);
        // PC wrap at the top of the address space
        do_fetch(0, 0, 1'b1, 32'hFFFF_FFFC);
        do_fetch(2, 0, 1'b0, 32'd0);
        do_fetch(0, 0, 1'b0, 32'd0);

        for (int n = 0; n < 150; n++) begin
            tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            do_fetch($urandom_range(0, 3),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                     ($urandom_range(0, 3) == 0), tgt);
        end

        // Reset in the middle of a REQ cycle with a coincident ack
        do_fetch(0, 0, 1'b0, 32'd0);
        do_reset(1'b1, 1);
        do_fetch(1, 1, 1'b1, 32'h0000_0200);

        // Misaligned taken target
        fault_pc = m_pc;
        do_fetch(0, 0, 1'b1, 32'h0000_0042);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            IMEM_ACK = 1'b1;
            STALL    = 1'($urandom);
            @(negedge CLK);
            check("trap_misalign", 32'(MISALIGN), 32'd1);
            check("trap_imem_req", 32'(IMEM_REQ), 32'd0);
            check("trap_instr_valid", 32'(INSTR_VALID), 32'd0);
            check("trap_pc", PC, fault_pc);
            check("trap_retire_count", RETIRE_COUNT, m_cnt);
            @(posedge CLK);
            #1;
        end
        do_reset(1'b0, 1);
        do_fetch(0, 0, 1'b0, 32'd0);
`else
        @(negedge CLK);
        check("misalign_tied_low", 32'(MISALIGN), 32'd0);
        check("masked_target_pc", PC, 32'h0000_0040);
        @(posedge CLK);
        #1;
        do_fetch(0, 0, 1'b0, 32'd0);
`endif

        repeat (3) step();
        check("addr_queue_drained", addr_q.size(), 32'd0);
        check("retire_queue_drained", ret_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
